alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler.sv | 140 ++++++++++++++
 tb/tb_alarm_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Three-zone alarm scheduler: per-zone sensor debounce, pending-event latching and a
// round-robin IDLE/ON/GAP buzzer sequencer with per-zone abort.
module alarm_scheduler #(
  parameter int unsigned DEB_LEN    = 8,
  parameter int unsigned ON_CYCLES  = 31,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] sensor,
  input  logic [2:0] clear,
  output logic [2:0] buzzer,
  output logic [2:0] pending,
  output logic [1:0] grant_id,
  output logic       busy
);

  localparam logic [7:0] DebMax  = 8'(DEB_LEN);
  localparam logic [7:0] OnLoad  = 8'(ON_CYCLES);
  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES);

  typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

  state_e          state_q, state_d;
  logic [2:0][7:0] deb_q, deb_d;
  logic [7:0]      dur_q, dur_d;
  logic [1:0]      last_q, last_d;
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      buzz_q, buzz_d;
  logic [1:0]      gid_q, gid_d;
  logic [2:0]      evt;
  logic [2:0]      grant_clr;
  logic [1:0]      pick;
  logic [2:0]      pick_oh;

  // Debounce: an event fires only on the edge the counter reaches DEB_LEN.
  always_comb begin
    deb_d = deb_q;
    evt   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      evt[i] = sensor[i] && (deb_q[i] == DebMax - 8'd1);
      if (!sensor[i]) begin
        deb_d[i] = 8'd0;
      end else if (deb_q[i] < DebMax) begin
        deb_d[i] = deb_q[i] + 8'd1;
      end
    end
  end

  // Round-robin pick, starting with the zone after last_q.
  always_comb begin
    pick = 2'd0;
    case (last_q)
      2'd1:    pick = pend_q[1] ? 2'd2 : pend_q[2] ? 2'd3 : pend_q[0] ? 2'd1 : 2'd0;
      2'd2:    pick = pend_q[2] ? 2'd3 : pend_q[0] ? 2'd1 : pend_q[1] ? 2'd2 : 2'd0;
      default: pick = pend_q[0] ? 2'd1 : pend_q[1] ? 2'd2 : pend_q[2] ? 2'd3 : 2'd0;
    endcase
    pick_oh = 3'b000;
    if (pick != 2'd0) pick_oh[pick - 2'd1] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    last_d    = last_q;
    buzz_d    = buzz_q;
    gid_d     = gid_q;
    grant_clr = 3'b000;
    case (state_q)
      StIdle: begin
        if (pick != 2'd0) begin
          state_d   = StOn;
          buzz_d    = pick_oh;
          gid_d     = pick;
          last_d    = pick;
          dur_d     = OnLoad;
          grant_clr = pick_oh;
        end
      end
      StOn: begin
        if (((clear & buzz_q) != 3'b000) || (dur_q <= 8'd1)) begin
          buzz_d = 3'b000;
          gid_d  = 2'd0;
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            dur_d   = GapLoad;
          end else begin
            state_d = StIdle;
            dur_d   = 8'd0;
          end
        end else begin
          dur_d = dur_q - 8'd1;
        end
      end
      StGap: begin
        if (dur_q <= 8'd1) begin
          state_d = StIdle;
          dur_d   = 8'd0;
        end else begin
          dur_d = dur_q - 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        buzz_d  = 3'b000;
        gid_d   = 2'd0;
        dur_d   = 8'd0;
      end
    endcase
    // A fresh qualification outranks both clear and grant so no event is lost.
    pend_d = (pend_q & ~clear & ~grant_clr) | evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      deb_q   <= '0;
      dur_q   <= 8'd0;
      last_q  <= 2'd3;
      pend_q  <= 3'b000;
      buzz_q  <= 3'b000;
      gid_q   <= 2'd0;
    end else if (ena) begin
      state_q <= state_d;
      deb_q   <= deb_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      buzz_q  <= buzz_d;
      gid_q   <= gid_d;
    end
  end

  assign buzzer   = buzz_q;
  assign pending  = pend_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: per-cycle expectations are queued with the stimulus
// and compared on the falling edge when the bench cycle count reaches them.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [2:0] sensor = 3'b000;
  logic [2:0] clear = 3'b000;
  logic [2:0] buzzer;
  logic [2:0] pending;
  logic [1:0] grant_id;
  logic       busy;

  alarm_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sensor   (sensor),
    .clear    (clear),
    .buzzer   (buzzer),
    .pending  (pending),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] v;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packed view {busy, grant_id, pending, buzzer}.
  function automatic logic [8:0] pk(input logic b, input logic [1:0] g, input logic [2:0] p,
                                     input logic [2:0] bz);
    return {b, g, p, bz};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic b, input logic [1:0] g,
                           input logic [2:0] p, input logic [2:0] bz);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.v   = pk(b, g, p, bz);
    q.push_back(e);
  endtask

  // One full alarm with default timing: 31 ON cycles then 4 GAP cycles.
  task automatic expect_alarm(input int start, input string tag, input logic [2:0] oh,
                              input logic [1:0] id, input logic [2:0] pend);
    for (int k = 0; k < 35; k++) begin
      if (k < 31) expect_at(start + k, tag, 1'b1, id, pend, oh);
      else        expect_at(start + k, tag, 1'b1, 2'd0, pend, 3'b000);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    check({tag, "_drain"}, q.size(), 0);
    q.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) check("onehot", 32'($onehot0(buzzer)), 32'd1);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) check({mon_e.tag, "_missed"}, 32'd0, 32'd1);
      else check(mon_e.tag, 32'(pk(busy, grant_id, pending, buzzer)), 32'(mon_e.v));
    end
  end

  initial begin
    int c;
    #2;
    check("reset_out", 32'(pk(busy, grant_id, pending, buzzer)), 32'd0);
    step(2);
    rst_n = 1'b1;

    // Single zone-1 alarm with full timing.
    step(1);
    c = cyc;
    expect_at(c + 7, "s1_pre", 1'b0, 2'd0, 3'b000, 3'b000);
    expect_at(c + 8, "s1_pend", 1'b0, 2'd0, 3'b001, 3'b000);
    expect_alarm(c + 9, "s1_alarm", 3'b001, 2'd1, 3'b000);
    expect_at(c + 44, "s1_idle", 1'b0, 2'd0, 3'b000, 3'b000);
    sensor = 3'b001;
    step(8);
    sensor = 3'b000;
    step(40);
    drain("s1");

    // Seven high samples never qualify.
    do_reset();
    c = cyc;
    for (int k = 7; k <= 12; k++) expect_at(c + k, "s2_quiet", 1'b0, 2'd0, 3'b000, 3'b000);
    sensor = 3'b001;
    step(7);
    sensor = 3'b000;
    step(8);
    drain("s2");

    // Simultaneous qualification, served round-robin 1, 2, 3.
    do_reset();
    c = cyc;
    expect_at(c + 8, "s3_pend", 1'b0, 2'd0, 3'b111, 3'b000);
    expect_alarm(c + 9, "s3_z1", 3'b001, 2'd1, 3'b110);
    expect_at(c + 44, "s3_idle1", 1'b0, 2'd0, 3'b110, 3'b000);
    expect_alarm(c + 45, "s3_z2", 3'b010, 2'd2, 3'b100);
    expect_at(c + 80, "s3_idle2", 1'b0, 2'd0, 3'b100, 3'b000);
    expect_alarm(c + 81, "s3_z3", 3'b100, 2'd3, 3'b000);
    expect_at(c + 116, "s3_idle3", 1'b0, 2'd0, 3'b000, 3'b000);
    sensor = 3'b111;
    step(8);
    sensor = 3'b000;
    step(110);
    drain("s3");

    // Abort zone 2 at ON cycle 10.
    do_reset();
    c = cyc;
    expect_at(c + 8, "s4_pend", 1'b0, 2'd0, 3'b010, 3'b000);
    for (int k = 9; k <= 18; k++) expect_at(c + k, "s4_on", 1'b1, 2'd2, 3'b000, 3'b010);
    for (int k = 19; k <= 22; k++) expect_at(c + k, "s4_gap", 1'b1, 2'd0, 3'b000, 3'b000);
    expect_at(c + 23, "s4_idle", 1'b0, 2'd0, 3'b000, 3'b000);
    sensor = 3'b010;
    step(8);
    sensor = 3'b000;
    step(10);
    clear = 3'b010;
    step(1);
    clear = 3'b000;
    step(6);
    drain("s4");

    // Five disabled cycles mid-ON stretch the wall-clock ON time by five.
    do_reset();
    c = cyc;
    for (int k = 9; k <= 44; k++) expect_at(c + k, "s5_on", 1'b1, 2'd1, 3'b000, 3'b001);
    for (int k = 45; k <= 48; k++) expect_at(c + k, "s5_gap", 1'b1, 2'd0, 3'b000, 3'b000);
    expect_at(c + 49, "s5_idle", 1'b0, 2'd0, 3'b000, 3'b000);
    sensor = 3'b001;
    step(8);
    sensor = 3'b000;
    step(10);
    ena = 1'b0;
    step(5);
    ena = 1'b1;
    step(28);
    drain("s5");

    // Reset mid-GAP with zone 3 pending drops the pending event.
    do_reset();
    c = cyc;
    expect_at(c + 8, "s6_pend", 1'b0, 2'd0, 3'b101, 3'b000);
    for (int k = 9; k <= 39; k++) expect_at(c + k, "s6_on", 1'b1, 2'd1, 3'b100, 3'b001);
    for (int k = 40; k <= 40; k++) expect_at(c + k, "s6_gap", 1'b1, 2'd0, 3'b100, 3'b000);
    sensor = 3'b101;
    step(8);
    sensor = 3'b000;
    step(33);
    rst_n = 1'b0;
    #1;
    check("s6_async_rst", 32'(pk(busy, grant_id, pending, buzzer)), 32'd0);
    drain("s6a");
    step(2);
    rst_n = 1'b1;
    c = cyc;
    for (int k = 1; k <= 40; k++) expect_at(c + k, "s6_after", 1'b0, 2'd0, 3'b000, 3'b000);
    step(42);
    drain("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
